// File: rtl/multdiv_sequencer.sv
// Issue/commit sequencer for the shared multi-cycle multdiv unit: freezes the front
// end, pulses start, waits for ready (with a watchdog) and commits around the MW write.
module multdiv_sequencer #(
  parameter logic [4:0] MULT_ALUOP  = 5'b00110,
  parameter logic [4:0] DIV_ALUOP   = 5'b00111,
  parameter int         TIMEOUT     = 40,
  parameter logic [4:0] RSTATUS_REG = 5'd30
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] ir_dx,
  input  logic        flush,
  input  logic        mw_wants_write,
  input  logic        md_ready,
  input  logic        md_exception,
  input  logic [31:0] md_result,
  output logic        ctrl_mult,
  output logic        ctrl_div,
  output logic        stall,
  output logic        squash_dx,
  output logic        commit_en,
  output logic [4:0]  commit_reg,
  output logic [31:0] commit_data
);

  localparam int WD_W = $clog2(TIMEOUT + 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_BUSY  = 3'd2,
    S_HOLD  = 3'd3,
    S_DONE  = 3'd4
  } state_e;

  function automatic logic is_md(input logic [31:0] ir);
    return (ir[31:27] == 5'd0) && ((ir[6:2] == MULT_ALUOP) || (ir[6:2] == DIV_ALUOP));
  endfunction

  state_e            state_q, state_d;
  logic              op_div_q, op_div_d;
  logic [4:0]        rd_q, rd_d;
  logic              kill_q, kill_d;
  logic [WD_W-1:0]   wd_q, wd_d;
  logic [31:0]       result_q, result_d;
  logic              exc_q, exc_d;

  logic              md_in_dx_s;
  logic              detect_s;
  logic              needs_write_s;
  logic              ctrl_mult_s, ctrl_div_s, stall_s, squash_dx_s, commit_en_s;
  logic [4:0]        commit_reg_s;
  logic [31:0]       commit_data_s;
  logic              unused_ir_s;

  assign unused_ir_s = ^{ir_dx[21:7], ir_dx[1:0]};

  // Next-state, watchdog, result latching and unmasked outputs.
  always_comb begin
    state_d       = state_q;
    op_div_d      = op_div_q;
    rd_d          = rd_q;
    kill_d        = kill_q;
    wd_d          = wd_q;
    result_d      = result_q;
    exc_d         = exc_q;
    ctrl_mult_s   = 1'b0;
    ctrl_div_s    = 1'b0;
    squash_dx_s   = 1'b0;
    commit_en_s   = 1'b0;
    commit_reg_s  = 5'd0;
    commit_data_s = 32'd0;
    stall_s       = 1'b0;
    detect_s      = 1'b0;
    md_in_dx_s    = is_md(ir_dx);
    needs_write_s = exc_q || (rd_q != 5'd0);

    case (state_q)
      S_IDLE: begin
        detect_s = md_in_dx_s && !flush;
        if (detect_s) begin
          state_d  = S_START;
          op_div_d = (ir_dx[6:2] == DIV_ALUOP);
          rd_d     = ir_dx[26:22];
          exc_d    = 1'b0;
          result_d = 32'd0;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_START: begin
        ctrl_mult_s = !op_div_q;
        ctrl_div_s  = op_div_q;
        wd_d        = {WD_W{1'b0}};
        kill_d      = kill_q || flush;
        state_d     = S_BUSY;
      end
      S_BUSY: begin
        wd_d = wd_q + WD_W'(1);
        if (md_ready || (wd_q == WD_LAST)) begin
          if (md_ready) begin
            result_d = md_result;
            exc_d    = md_exception;
          end else begin
            exc_d = 1'b1;
          end
          // A killed op drains the unit but never reaches HOLD or DONE.
          if (kill_q || flush) begin
            state_d = S_IDLE;
          end else begin
            state_d = S_HOLD;
          end
          kill_d = 1'b0;
        end else begin
          kill_d  = kill_q || flush;
          state_d = S_BUSY;
        end
      end
      S_HOLD: begin
        if (flush) begin
          state_d = S_IDLE;
        end else if (!needs_write_s) begin
          state_d = S_DONE;
        end else begin
          commit_en_s = !mw_wants_write;
          if (commit_en_s) begin
            state_d = S_DONE;
          end else begin
            state_d = S_HOLD;
          end
        end
      end
      S_DONE: begin
        squash_dx_s = 1'b1;
        state_d     = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        kill_d  = 1'b0;
      end
    endcase

    if (kill_q) begin
      stall_s = md_in_dx_s;
    end else begin
      stall_s = detect_s || (state_q == S_START) || (state_q == S_BUSY) || (state_q == S_HOLD);
    end

    if (commit_en_s) begin
      if (exc_q) begin
        commit_reg_s  = RSTATUS_REG;
        commit_data_s = op_div_q ? 32'd5 : 32'd4;
      end else begin
        commit_reg_s  = rd_q;
        commit_data_s = result_q;
      end
    end else begin
      commit_reg_s  = 5'd0;
      commit_data_s = 32'd0;
    end
  end

  // Outputs are forced low for as long as reset is held, independent of the clock.
  assign ctrl_mult   = reset ? ctrl_mult_s   : 1'b0;
  assign ctrl_div    = reset ? ctrl_div_s    : 1'b0;
  assign stall       = reset ? stall_s       : 1'b0;
  assign squash_dx   = reset ? squash_dx_s   : 1'b0;
  assign commit_en   = reset ? commit_en_s   : 1'b0;
  assign commit_reg  = reset ? commit_reg_s  : 5'd0;
  assign commit_data = reset ? commit_data_s : 32'd0;

  // State register with asynchronous active-low reset.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      op_div_q <= 1'b0;
      rd_q     <= 5'd0;
      kill_q   <= 1'b0;
      wd_q     <= {WD_W{1'b0}};
      result_q <= 32'd0;
      exc_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_div_q <= op_div_d;
      rd_q     <= rd_d;
      kill_q   <= kill_d;
      wd_q     <= wd_d;
      result_q <= result_d;
      exc_q    <= exc_d;
    end
  end

endmodule

// File: tb/tb_multdiv_sequencer.sv
// Scoreboard bench for multdiv_sequencer: stimulus queues expected start pulses and
// commits, an independent negedge monitor pops and compares them.
module tb_multdiv_sequencer;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] ir_dx;
  logic        flush, mw_wants_write, md_ready, md_exception;
  logic [31:0] md_result;
  logic        ctrl_mult, ctrl_div, stall, squash_dx, commit_en;
  logic [4:0]  commit_reg;
  logic [31:0] commit_data;

  int pass_cnt  = 0;
  int total_cnt = 0;

  logic        exp_pulse_q[$];
  logic [36:0] exp_commit_q[$];
  logic        mon_pulse;
  logic [36:0] mon_commit;

  multdiv_sequencer dut (
    .clock(clock), .reset(reset), .ir_dx(ir_dx), .flush(flush),
    .mw_wants_write(mw_wants_write), .md_ready(md_ready),
    .md_exception(md_exception), .md_result(md_result),
    .ctrl_mult(ctrl_mult), .ctrl_div(ctrl_div), .stall(stall),
    .squash_dx(squash_dx), .commit_en(commit_en),
    .commit_reg(commit_reg), .commit_data(commit_data)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  function automatic logic [31:0] mk(input logic [4:0] rd, input logic div);
    logic [31:0] ir;
    ir        = 32'd0;
    ir[26:22] = rd;
    ir[21:17] = 5'd2;
    ir[16:12] = 5'd3;
    ir[6:2]   = div ? 5'b00111 : 5'b00110;
    return ir;
  endfunction

  // Monitor: every start pulse and every commit must match the head of its queue.
  always @(negedge clock) begin
    if (ctrl_mult || ctrl_div) begin
      if (exp_pulse_q.size() == 0) begin
        chk("unexpected_start_pulse", {62'd0, ctrl_div, ctrl_mult}, 64'd0);
      end else begin
        mon_pulse = exp_pulse_q.pop_front();
        chk("start_pulse", {62'd0, ctrl_div, ctrl_mult}, mon_pulse ? 64'd2 : 64'd1);
      end
    end
    if (commit_en) begin
      if (exp_commit_q.size() == 0) begin
        chk("unexpected_commit", {27'd0, commit_reg, commit_data}, 64'd0);
      end else begin
        mon_commit = exp_commit_q.pop_front();
        chk("commit_reg", {59'd0, commit_reg}, {59'd0, mon_commit[36:32]});
        chk("commit_data", {32'd0, commit_data}, {32'd0, mon_commit[31:0]});
      end
    end else begin
      chk("commit_fields_zero_when_idle", {27'd0, commit_reg, commit_data}, 64'd0);
    end
  end

  task automatic tick();
    @(posedge clock);
    #2;
  endtask

  task automatic chk_all_zero(input string name);
    chk(name, {22'd0, ctrl_mult, ctrl_div, stall, squash_dx, commit_en, commit_reg, commit_data}, 64'd0);
  endtask

  // Detect cycle then START cycle; returns in START at +3 after the edge.
  task automatic issue(input string tag, input logic [4:0] rd, input logic div);
    ir_dx = mk(rd, div);
    #1;
    chk({tag, "_detect_stall"}, {63'd0, stall}, 64'd1);
    exp_pulse_q.push_back(div);
    tick();
    #1;
    chk({tag, "_start_stall"}, {63'd0, stall}, 64'd1);
  endtask

  task automatic busy(input string tag, input int n);
    int bad = 0;
    for (int i = 0; i < n; i++) begin
      tick();
      #1;
      if (stall !== 1'b1 || commit_en !== 1'b0) bad++;
    end
    chk({tag, "_busy_stall_no_commit"}, bad, 64'd0);
  endtask

  task automatic finish_commit(input string tag);
    #1;
    chk({tag, "_hold_commit_en"}, {63'd0, commit_en}, 64'd1);
    chk({tag, "_hold_stall"}, {63'd0, stall}, 64'd1);
    tick();
    #1;
    chk({tag, "_done_squash"}, {63'd0, squash_dx}, 64'd1);
    chk({tag, "_done_stall"}, {63'd0, stall}, 64'd0);
    tick();
    ir_dx = 32'd0;
    #1;
    chk({tag, "_idle_squash"}, {63'd0, squash_dx}, 64'd0);
  endtask

  initial begin
    #50000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b0; flush = 1'b0; mw_wants_write = 1'b0;
    md_ready = 1'b0; md_exception = 1'b0; md_result = 32'd0;
    ir_dx = mk(5'd5, 1'b0);
    #3;
    chk_all_zero("reset_outputs_zero");
    tick();
    tick();
    reset = 1'b1;
    ir_dx = 32'd0;
    #1;
    chk("idle_no_stall", {63'd0, stall}, 64'd0);
    tick();

    // mul r5 = 6*7, ready 20 cycles after the pulse, MW idle
    issue("mul", 5'd5, 1'b0);
    busy("mul", 19);
    tick();
    md_ready = 1'b1; md_result = 32'd42;
    exp_commit_q.push_back({5'd5, 32'd42});
    tick();
    md_ready = 1'b0; md_result = 32'hdead_beef;
    finish_commit("mul");
    tick();

    // div with exception at ready
    issue("divx", 5'd7, 1'b1);
    busy("divx", 3);
    tick();
    md_ready = 1'b1; md_exception = 1'b1; md_result = 32'h1234_5678;
    exp_commit_q.push_back({5'd30, 32'd5});
    tick();
    md_ready = 1'b0; md_exception = 1'b0;
    finish_commit("divx");
    tick();

    // MW owns the write port for 3 HOLD cycles
    issue("mw", 5'd9, 1'b0);
    busy("mw", 5);
    tick();
    md_ready = 1'b1; md_result = 32'd1234;
    tick();
    md_ready = 1'b0; md_result = 32'hffff_ffff; mw_wants_write = 1'b1;
    for (int i = 0; i < 3; i++) begin
      if (i > 0) tick();
      #1;
      chk("mw_blocked_commit_en", {63'd0, commit_en}, 64'd0);
      chk("mw_blocked_stall", {63'd0, stall}, 64'd1);
    end
    tick();
    mw_wants_write = 1'b0;
    exp_commit_q.push_back({5'd9, 32'd1234});
    finish_commit("mw");
    tick();

    // watchdog: no ready, exactly 40 BUSY cycles then rstatus=4
    issue("wdog", 5'd4, 1'b0);
    busy("wdog", 40);
    exp_commit_q.push_back({5'd30, 32'd4});
    tick();
    finish_commit("wdog");
    tick();

    // flush in BUSY, new mul during drain
    issue("fl", 5'd6, 1'b0);
    busy("fl", 3);
    tick();
    flush = 1'b1;
    #1;
    chk("fl_flush_cycle_stall", {63'd0, stall}, 64'd1);
    tick();
    flush = 1'b0; ir_dx = 32'd0;
    #1;
    chk("fl_stall_dropped", {63'd0, stall}, 64'd0);
    tick();
    ir_dx = mk(5'd8, 1'b0);
    #1;
    chk("fl_new_mul_stall", {63'd0, stall}, 64'd1);
    tick();
    #1;
    chk("fl_no_pulse_in_drain", {62'd0, ctrl_div, ctrl_mult}, 64'd0);
    tick();
    md_ready = 1'b1; md_result = 32'd999;
    #1;
    chk("fl_ready_cycle_stall", {63'd0, stall}, 64'd1);
    tick();
    md_ready = 1'b0;
    #1;
    chk("fl_idle_detect_stall", {63'd0, stall}, 64'd1);
    chk("fl_killed_no_commit", {63'd0, commit_en}, 64'd0);
    exp_pulse_q.push_back(1'b0);
    tick();
    #1;
    chk("fl_new_start_pulse", {63'd0, ctrl_mult}, 64'd1);
    busy("fl2", 2);
    tick();
    md_ready = 1'b1; md_result = 32'd77;
    exp_commit_q.push_back({5'd8, 32'd77});
    tick();
    md_ready = 1'b0;
    finish_commit("fl2");
    tick();

    // async reset mid-BUSY, then a mul to r0
    issue("rst", 5'd3, 1'b0);
    busy("rst", 4);
    reset = 1'b0;
    #1;
    chk_all_zero("rst_async_outputs_zero");
    tick();
    #1;
    chk_all_zero("rst_held_outputs_zero");
    tick();
    reset = 1'b1; ir_dx = 32'd0;
    for (int i = 0; i < 3; i++) begin
      tick();
      #1;
      chk("rst_idle_no_stall", {63'd0, stall}, 64'd0);
    end
    tick();
    issue("r0", 5'd0, 1'b0);
    busy("r0", 2);
    tick();
    md_ready = 1'b1; md_result = 32'd55;
    tick();
    md_ready = 1'b0;
    #1;
    chk("r0_hold_no_commit", {63'd0, commit_en}, 64'd0);
    chk("r0_hold_stall", {63'd0, stall}, 64'd1);
    tick();
    #1;
    chk("r0_done_squash", {63'd0, squash_dx}, 64'd1);
    tick();
    ir_dx = 32'd0;
    tick();
    tick();

    chk("pending_pulses_left", exp_pulse_q.size(), 64'd0);
    chk("pending_commits_left", exp_commit_q.size(), 64'd0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
